// File: rtl/spi_miso_rx_fifo.sv
// spi_miso_rx_fifo
//   Deserialises spi_miso_in into DATA_W-bit words while spi_cs is low and
//   buffers completed words in a show-ahead FIFO. Overflow and framing
//   errors are reported through sticky flags that read_req clears.
//
// Ports
//   spi_clk       sole clock, rising edge
//   spi_rst       synchronous active-high reset
//   spi_cs        chip select, active low
//   read_req      one-cycle pulse: arm receiver, clear error flags
//   spi_miso_in   serial data in
//   rd_en         pop FIFO head
//   spi_miso_out  FIFO head word (0 when empty)
//   data_av       FIFO not empty
//   fifo_full     FIFO holds FIFO_DEPTH words
//   overflow      sticky: completed word dropped
//   frame_err     sticky: spi_cs rose mid-word
//   busy          receiver is shifting
//   spi_mosi_out  fill-pattern bit
//   rx_word_cnt   words pushed, wraps (only with SPI_RX_WORD_CNT_EN)
//
// Optional feature macro: SPI_RX_WORD_CNT_EN
//
// state | meaning
// IDLE  | waiting for read_req, spi_cs ignored
// ARMED | armed, first edge with spi_cs low starts the word
// SHIFT | sampling one bit per edge while spi_cs is low
module spi_miso_rx_fifo #(
   parameter int                DATA_W     = 8,
   parameter int                FIFO_DEPTH = 4,
   parameter bit                LSB_FIRST  = 1'b0,
   parameter logic [DATA_W-1:0] FILL_WORD  = DATA_W'(8'hFF)
) (
   input  logic              spi_clk,
   input  logic              spi_rst,
   input  logic              spi_cs,
   input  logic              read_req,
   input  logic              spi_miso_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] spi_miso_out,
   output logic              data_av,
   output logic              fifo_full,
   output logic              overflow,
   output logic              frame_err,
   output logic              busy,
   output logic              spi_mosi_out
`ifdef SPI_RX_WORD_CNT_EN
   ,
   output logic [15:0]       rx_word_cnt
`endif
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shift_reg, shift_nxt;
   logic              sample, frame_abort, word_done;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [LVL_W-1:0]  level;
   logic              pop, push_ok, drop;
   logic [CNT_W-1:0]  fill_idx;

   always_comb begin
      state_nxt   = state;
      sample      = 1'b0;
      frame_abort = 1'b0;
      case (state)
         IDLE: begin
            if (read_req) state_nxt = ARMED;
         end
         ARMED: begin
            if (!spi_cs) begin
               state_nxt = SHIFT;
               sample    = 1'b1;
            end
         end
         SHIFT: begin
            if (spi_cs) begin
               state_nxt   = IDLE;
               frame_abort = (bit_cnt != '0);
            end else begin
               sample = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      if (LSB_FIRST) shift_nxt = {spi_miso_in, shift_reg[DATA_W-1:1]};
      else           shift_nxt = {shift_reg[DATA_W-2:0], spi_miso_in};
   end

   // The completing bit goes straight into the FIFO via shift_nxt.
   assign word_done = sample && (bit_cnt == LAST_BIT);

   always_ff @(posedge spi_clk) begin
      if (spi_rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         state <= state_nxt;
         if (sample) begin
            shift_reg <= shift_nxt;
            bit_cnt   <= word_done ? '0 : bit_cnt + CNT_W'(1);
         end else begin
            bit_cnt <= '0;
         end
      end
   end

   // A pop frees a slot on the same edge, so a push into a full FIFO
   // still lands when rd_en is high.
   assign pop     = rd_en && (level != '0);
   assign push_ok = word_done && (!fifo_full || pop);
   assign drop    = word_done && fifo_full && !pop;

   always_ff @(posedge spi_clk) begin
      if (push_ok) mem[wr_ptr] <= shift_nxt;
   end

   always_ff @(posedge spi_clk) begin
      if (spi_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level + LVL_W'(push_ok) - LVL_W'(pop);
      end
   end

   // A new error on the same edge as read_req wins over the clear.
   always_ff @(posedge spi_clk) begin
      if (spi_rst) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (drop)          overflow <= 1'b1;
         else if (read_req) overflow <= 1'b0;
         if (frame_abort)   frame_err <= 1'b1;
         else if (read_req) frame_err <= 1'b0;
      end
   end

`ifdef SPI_RX_WORD_CNT_EN
   always_ff @(posedge spi_clk) begin
      if (spi_rst)      rx_word_cnt <= '0;
      else if (push_ok) rx_word_cnt <= rx_word_cnt + 16'd1;
   end
`endif

   assign data_av      = (level != '0);
   assign fifo_full    = (level == LVL_W'(FIFO_DEPTH));
   assign spi_miso_out = data_av ? mem[rd_ptr] : '0;
   assign busy         = (state == SHIFT);

   assign fill_idx     = LSB_FIRST ? bit_cnt : (LAST_BIT - bit_cnt);
   assign spi_mosi_out = (state == SHIFT) && !spi_cs && FILL_WORD[fill_idx];

endmodule

// File: tb/tb_spi_miso_rx_fifo.sv
// Bench for spi_miso_rx_fifo: a table of vectors for basic reception,
// directed sequences for FIFO overflow, framing errors and reset, a
// second instance in LSB-first 12-bit mode, and a randomized run against
// a queue-based reference model.
module tb_spi_miso_rx_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, cs0, req0, miso0, rd0;
   logic [7:0]  head0;
   logic        av0, full0, ovf0, ferr0, busy0, mosi0;
   logic        cs1, req1, miso1, rd1;
   logic [11:0] head1;
   logic        av1, full1, ovf1, ferr1, busy1, mosi1;
`ifdef SPI_RX_WORD_CNT_EN
   logic [15:0] wcnt0, wcnt1;
`endif

   spi_miso_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .LSB_FIRST(1'b0), .FILL_WORD(8'hA5)) u_dut0 (
      .spi_clk(clk), .spi_rst(rst), .spi_cs(cs0), .read_req(req0),
      .spi_miso_in(miso0), .rd_en(rd0), .spi_miso_out(head0), .data_av(av0),
      .fifo_full(full0), .overflow(ovf0), .frame_err(ferr0), .busy(busy0),
      .spi_mosi_out(mosi0)
`ifdef SPI_RX_WORD_CNT_EN
      , .rx_word_cnt(wcnt0)
`endif
   );

   spi_miso_rx_fifo #(.DATA_W(12), .FIFO_DEPTH(8), .LSB_FIRST(1'b1), .FILL_WORD(12'hA5C)) u_dut1 (
      .spi_clk(clk), .spi_rst(rst), .spi_cs(cs1), .read_req(req1),
      .spi_miso_in(miso1), .rd_en(rd1), .spi_miso_out(head1), .data_av(av1),
      .fifo_full(full1), .overflow(ovf1), .frame_err(ferr1), .busy(busy1),
      .spi_mosi_out(mosi1)
`ifdef SPI_RX_WORD_CNT_EN
      , .rx_word_cnt(wcnt1)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  fill0_v = 8'hA5;
   logic [11:0] fill1_v = 12'hA5C;

   // reference model of u_dut0: mode 0 idle, 1 armed, 2 shifting
   int         m_mode;
   bit         m_bits[$];
   logic [7:0] m_fifo[$];
   bit         m_ovf, m_ferr;
   logic [15:0] m_wcnt;

   function automatic void model_step();
      bit pop, push, ferr_set;
      logic [7:0] w;
      int sz;
      if (rst) begin
         m_mode = 0; m_bits.delete(); m_fifo.delete();
         m_ovf = 0; m_ferr = 0; m_wcnt = 0;
         return;
      end
      push = 0; ferr_set = 0; w = 0;
      sz  = m_fifo.size();
      pop = rd0 && (sz > 0);
      if (m_mode == 0) begin
         if (req0) m_mode = 1;
      end else if (cs0) begin
         if (m_mode == 2) begin
            if (m_bits.size() != 0) ferr_set = 1;
            m_bits.delete();
            m_mode = 0;
         end
      end else begin
         m_mode = 2;
         m_bits.push_back(miso0);
         if (m_bits.size() == 8) begin
            foreach (m_bits[i]) w = w | (8'(m_bits[i]) << (7 - i));
            push = 1;
            m_bits.delete();
         end
      end
      if (req0) begin m_ovf = 0; m_ferr = 0; end
      if (ferr_set) m_ferr = 1;
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
         if (sz < 4 || pop) begin m_fifo.push_back(w); m_wcnt++; end
         else m_ovf = 1;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1; cs0 = 1; req0 = 0; miso0 = 0; rd0 = 0;
      cs1 = 1; req1 = 0; miso1 = 0; rd1 = 0;
      cycle(); cycle();
      rst = 0;
   endtask

   task automatic arm0();
      cs0 = 1; req0 = 1; rd0 = 0;
      cycle();
      req0 = 0;
   endtask

   task automatic send_word0(input logic [7:0] w, input bit rd_last);
      for (int i = 0; i < 8; i++) begin
         cs0 = 0; miso0 = w[7-i]; rd0 = (i == 7) ? rd_last : 1'b0;
         cycle();
      end
      rd0 = 0;
   endtask

   typedef struct {
      logic cs, req, miso, rd;
      logic [13:0] exp; // {head, av, full, ovf, ferr, busy, mosi}
   } vec_t;
   vec_t vecs[$];

   task automatic add_vec(input logic cs, req, miso, rd,
                          input logic [7:0] head, input logic av, busy, mosi);
      vec_t v;
      v.cs = cs; v.req = req; v.miso = miso; v.rd = rd;
      v.exp = {head, av, 1'b0, 1'b0, 1'b0, busy, mosi};
      vecs.push_back(v);
   endtask

   initial begin
      logic [7:0]  w1, w2, exp_pop[4];
      logic [11:0] w12;
      logic [13:0] act, exp;
      logic        m_mosi;
      int          rd_pct;

      w1 = 8'hAA; w2 = 8'hE1;
      add_vec(1, 1, 0, 0, 8'h00, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         add_vec(0, 0, w1[7-i], 0, (i == 7) ? w1 : 8'h00, i == 7, 1, fill0_v[7 - ((i + 1) % 8)]);
      for (int i = 0; i < 8; i++)
         add_vec(0, 0, w2[7-i], 0, w1, 1, 1, fill0_v[7 - ((i + 1) % 8)]);
      add_vec(1, 0, 0, 1, w2,    1, 0, 0);
      add_vec(1, 0, 0, 1, 8'h00, 0, 0, 0);
      add_vec(1, 0, 0, 1, 8'h00, 0, 0, 0);

      do_reset();
      chk("reset0", {head0, av0, full0, ovf0, ferr0, busy0, mosi0}, 14'h0);
      chk("reset1", {head1, av1, full1, ovf1, ferr1, busy1, mosi1}, 18'h0);

      foreach (vecs[i]) begin
         cs0 = vecs[i].cs; req0 = vecs[i].req; miso0 = vecs[i].miso; rd0 = vecs[i].rd;
         cycle();
         chk($sformatf("vec%0d", i), {head0, av0, full0, ovf0, ferr0, busy0, mosi0}, vecs[i].exp);
      end
      req0 = 0; rd0 = 0;

      // overflow: five words into a four-deep FIFO
      do_reset(); arm0();
      exp_pop = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int k = 0; k < 4; k++) send_word0(exp_pop[k], 0);
      chk("full_after4", full0, 1);
      chk("no_ovf_after4", ovf0, 0);
      send_word0(8'h55, 0);
      chk("ovf_after5", {ovf0, full0, head0}, {1'b1, 1'b1, 8'h11});
      cs0 = 1; cycle();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ovf_pop%0d", k), head0, exp_pop[k]);
         rd0 = 1; cycle(); rd0 = 0;
      end
      chk("ovf_drained", {av0, head0, ovf0}, {1'b0, 8'h00, 1'b1});
      arm0();
      chk("ovf_cleared", ovf0, 0);

      // push and pop on the same edge while full
      do_reset(); arm0();
      for (int k = 0; k < 4; k++) send_word0(exp_pop[k], 0);
      send_word0(8'h55, 1);
      chk("pushpop_full", {ovf0, full0, head0}, {1'b0, 1'b1, 8'h22});
      cs0 = 1; cycle();
      rd0 = 1; cycle(); cycle(); cycle();
      chk("pushpop_tail", head0, 8'h55);
      cycle(); rd0 = 0;
      chk("pushpop_empty", av0, 0);

      // framing error
      do_reset(); arm0();
      for (int k = 0; k < 3; k++) begin cs0 = 0; miso0 = 1; cycle(); end
      chk("busy_mid", busy0, 1);
      cs0 = 1; cycle();
      chk("frame_err", {ferr0, busy0, av0}, {1'b1, 1'b0, 1'b0});
      for (int k = 0; k < 10; k++) begin cs0 = 0; miso0 = k[0]; cycle(); end
      chk("idle_ignores_cs", {busy0, av0}, 2'b00);
      arm0();
      chk("ferr_cleared", ferr0, 0);

      // reset mid-word with two words buffered
      do_reset(); arm0();
      send_word0(8'h5A, 0); send_word0(8'hC3, 0);
`ifdef SPI_RX_WORD_CNT_EN
      chk("wcnt_two", wcnt0, 16'd2);
`endif
      for (int k = 0; k < 3; k++) begin cs0 = 0; miso0 = 1; cycle(); end
      rst = 1; cycle(); rst = 0;
      chk("rst_mid", {head0, av0, full0, ovf0, ferr0, busy0, mosi0}, 14'h0);
`ifdef SPI_RX_WORD_CNT_EN
      chk("wcnt_rst", wcnt0, 16'd0);
`endif
      for (int k = 0; k < 4; k++) begin cs0 = 0; miso0 = 1; cycle(); end
      chk("rst_idle", busy0, 0);
      arm0(); send_word0(8'h96, 0);
      chk("rst_realign", {av0, head0}, {1'b1, 8'h96});

      // LSB-first 12-bit instance
      do_reset();
      cs1 = 1; req1 = 1; cycle(); req1 = 0;
      for (int i = 0; i < 12; i++) begin
         cs1 = 0; miso1 = (i == 0); cycle();
         chk($sformatf("lsb_mosi%0d", i), {busy1, mosi1}, {1'b1, fill1_v[(i + 1) % 12]});
      end
      chk("lsb_word1", {av1, head1}, {1'b1, 12'h001});
      w12 = 12'hB37;
      for (int i = 0; i < 12; i++) begin cs1 = 0; miso1 = w12[i]; cycle(); end
      cs1 = 1; rd1 = 1; cycle();
      chk("lsb_word2", head1, w12);
      cycle(); rd1 = 0;
      chk("lsb_empty", {av1, head1}, 13'h0);

      // randomized run against the model
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         rd_pct = (n < 2000) ? 5 : 30;
         rst   = ($urandom_range(0, 299) == 0);
         cs0   = ($urandom_range(0, 19) == 0);
         req0  = (m_mode != 2) && ($urandom_range(0, 3) == 0);
         miso0 = $urandom_range(0, 1);
         rd0   = ($urandom_range(0, 99) < rd_pct);
         cycle();
         m_mosi = (m_mode == 2) && !cs0 && fill0_v[7 - m_bits.size()];
         exp = {(m_fifo.size() > 0) ? m_fifo[0] : 8'h00, m_fifo.size() > 0,
                m_fifo.size() == 4, m_ovf, m_ferr, m_mode == 2, m_mosi};
         act = {head0, av0, full0, ovf0, ferr0, busy0, mosi0};
         chk($sformatf("rand%0d", n), act, exp);
`ifdef SPI_RX_WORD_CNT_EN
         chk($sformatf("rand_wcnt%0d", n), wcnt0, m_wcnt);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
